// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared types and default geometry for the convolution-engine frame adapter.
//   state_t          : adapter sequencing states
//   IMG_W/IMG_H/K    : default frame and kernel geometry
//   DATA_W           : pixel / result word width
//   OUT_W/OUT_H      : valid-convolution output dimensions
//   N_PIX/N_OUT      : flat array lengths for input pixels and results
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int DATA_W = 32;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int N_OUT  = OUT_W * OUT_H;

    typedef enum logic [2:0] {
        FILL,
        CLEAR,
        START,
        WAIT,
        DRAIN
    } state_t;

endpackage

// File: rtl/cnn_result_streamer.sv
// ---------------------------------------------------------------------------
// cnn_result_streamer
// Walks the engine result array in raster order and presents each word on a
// registered valid/ready source (no skid buffer: outputs hold while stalled).
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   load               : one-cycle request to begin streaming from word 0
//   eng_result[N_OUT]  : engine output array, held stable by the engine
//   m_valid/m_ready    : downstream handshake
//   m_data, m_last     : current word and end-of-frame marker
//   last_hs            : combinational, high on the final word's handshake
// ---------------------------------------------------------------------------
module cnn_result_streamer #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] eng_result [N_OUT],
    input  logic                     m_ready,
    output logic                     m_valid,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_last,
    output logic                     last_hs
);

    localparam int AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [AW-1:0]            out_idx_q, out_idx_d;
    logic                     m_valid_q, m_valid_d;
    logic signed [DATA_W-1:0] m_data_q,  m_data_d;
    logic                     m_last_q,  m_last_d;
    logic                     hs;

    assign hs = m_valid_q && m_ready;

    always_comb begin
        out_idx_d = out_idx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (load) begin
            out_idx_d = '0;
            m_valid_d = 1'b1;
            m_data_d  = eng_result[0];
            m_last_d  = (N_OUT == 1);
        end else if (hs) begin
            if (m_last_q) begin
                out_idx_d = '0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end else begin
                // out_idx always names the word currently on m_data, so the
                // next word is fetched as the handshake retires this one.
                out_idx_d = out_idx_q + 1'b1;
                m_data_d  = eng_result[out_idx_d];
                m_last_d  = (out_idx_d == AW'(N_OUT - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            out_idx_q <= out_idx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign last_hs = hs && m_last_q;

endmodule

// File: rtl/cnn_frame_io.sv
// ---------------------------------------------------------------------------
// cnn_frame_io
// Host-side frame adapter for the convolution engine: fills the engine's
// input pixel array from a stream, re-arms and starts the engine, waits for
// done, then streams the results back out.
// Optional feature: define CNN_IO_TIMEOUT_EN to add a WAIT watchdog that
// raises sticky err after TIMEOUT_CYC cycles without eng_done and abandons
// the frame; undefined, err is tied low and WAIT is unbounded.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   : input pixel stream, raster order
//   frame_ram[IMG_W*IMG_H]   : engine input pixel array (not reset)
//   eng_rst, eng_start       : one-cycle engine re-arm and start pulses
//   eng_done                 : engine done level, sticky until eng_rst
//   eng_result[OUT_W*OUT_H]  : engine result array
//   m_valid/m_ready/m_data   : result stream, m_last marks the final word
//   busy                     : high whenever not accepting pixels
//   frame_cnt                : completed frames, wraps
//   err                      : sticky watchdog error
// ---------------------------------------------------------------------------
module cnn_frame_io #(
    parameter int IMG_W       = cnn_pkg::IMG_W,
    parameter int IMG_H       = cnn_pkg::IMG_H,
    parameter int K           = cnn_pkg::K,
    parameter int DATA_W      = cnn_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic        [DATA_W-1:0] s_data,
    output logic        [DATA_W-1:0] frame_ram  [IMG_W*IMG_H],
    output logic                     eng_rst,
    output logic                     eng_start,
    input  logic                     eng_done,
    input  logic signed [DATA_W-1:0] eng_result [(IMG_W-K+1)*(IMG_H-K+1)],
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic              [15:0] frame_cnt,
    output logic                     err
);
    import cnn_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NOUT = (IMG_W - K + 1) * (IMG_H - K + 1);
    localparam int PAW  = (NPIX > 1) ? $clog2(NPIX) : 1;

    // The watchdog counter is 16 bits wide.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range");
    end

    state_t         state_q, state_d;
    logic [PAW-1:0] pix_idx_q, pix_idx_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           fill_hs;
    logic           load;
    logic           last_hs;

`ifdef CNN_IO_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        err_q, err_d;
`endif

    assign fill_hs = (state_q == FILL) && s_valid;

    always_comb begin
        state_d     = state_q;
        pix_idx_d   = pix_idx_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;
`ifdef CNN_IO_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            FILL: begin
                if (s_valid) begin
                    if (pix_idx_q == PAW'(NPIX - 1)) begin
                        pix_idx_d = '0;
                        state_d   = CLEAR;
                    end else begin
                        pix_idx_d = pix_idx_q + 1'b1;
                    end
                end
            end
            CLEAR: state_d = START;
            START: begin
                state_d = WAIT;
`ifdef CNN_IO_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (eng_done) begin
                    load    = 1'b1;
                    state_d = DRAIN;
                end
`ifdef CNN_IO_TIMEOUT_EN
                else if (wd_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    // Abandon the frame: nothing is emitted and no frame
                    // is counted.
                    err_d   = 1'b1;
                    state_d = FILL;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
            end
            DRAIN: begin
                if (last_hs) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            pix_idx_q   <= '0;
            frame_cnt_q <= '0;
`ifdef CNN_IO_TIMEOUT_EN
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pix_idx_q   <= pix_idx_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CNN_IO_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Pixel storage keeps its contents across reset; only the write index
    // is cleared, so a partial frame is simply overwritten.
    always_ff @(posedge clk) begin
        if (fill_hs && !rst) begin
            frame_ram[pix_idx_q] <= s_data;
        end
    end

    cnn_result_streamer #(
        .DATA_W (DATA_W),
        .N_OUT  (NOUT)
    ) u_streamer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .eng_result (eng_result),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .last_hs    (last_hs)
    );

    assign s_ready   = (state_q == FILL);
    assign eng_rst   = (state_q == CLEAR);
    assign eng_start = (state_q == START);
    assign busy      = (state_q != FILL);
    assign frame_cnt = frame_cnt_q;

`ifdef CNN_IO_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
